ring_phase_monitor: RTL and testbench
=====================================

Name: ring_phase_monitor

Overview:
- Downstream consumer of the 4-bit one-hot ring counter output.
- Samples the rotating one-hot phase every clock and checks it is exactly one-hot and advancing in order 0001->0010->0100->1000->0001.
- Acquires lock after a run of correct steps, counts full revolutions, and raises a sticky fault with a cause code on any violation.
- Feeds status/LED and debug logic in the lab top level.

Parameters:
- LOCK_COUNT, 4, consecutive correct steps required to enter LOCKED (legal range 1..15).
- REV_W, 8, width of the revolution counter.

Ports:
- clock  input  1  rising-edge system clock, same clock as the ring counter.
- reset_n  input  1  asynchronous, active-low reset.
- phase  input  4  one-hot phase from the ring counter.
- clear  input  1  synchronous clear of fault/count status, active-high.
- locked  output  1  high while in LOCKED.
- err  output  1  sticky fault flag.
- err_code  output  2  fault cause: 00 none, 01 not one-hot, 10 wrong order, 11 stall.
- rev_count  output  REV_W  saturating count of completed revolutions.
- rev_pulse  output  1  one-cycle pulse on each 1000->0001 step while LOCKED.
- cur_index  output  2  binary index of last valid sampled phase (0001->0, 0010->1, 0100->2, 1000->3).

Behaviour:
- Reset (reset_n low, async): state IDLE; prev=0000; step count=0; all outputs 0.
- Each rising edge compares input phase against registered prev (last valid sample).
- Classification:
  - valid: exactly one bit set.
  - correct: phase == rotate-left-by-1(prev).
  - stall: phase == prev.
  - wrong: valid but neither correct nor stall.
- All outputs are registered and reflect the sample taken at the same edge (zero-cycle decision, visible after that edge).
- IDLE:
  - valid -> ACQUIRE; prev=phase; count=0.
  - invalid -> stay IDLE; no error.
- ACQUIRE:
  - correct -> count+1; when count reaches LOCK_COUNT -> LOCKED, locked=1.
  - stall or wrong -> count=0; stay ACQUIRE; prev=phase.
  - invalid -> IDLE.
  - No faults are raised in ACQUIRE.
- LOCKED:
  - correct -> stay; on prev=1000 and phase=0001, rev_pulse=1 for that cycle and rev_count+1, saturating at all-ones.
  - invalid -> FAULT, err_code=01.
  - wrong -> FAULT, err_code=10.
  - stall -> FAULT, err_code=11.
  - On entering FAULT: err=1, locked=0.
- FAULT:
  - prev frozen; locked=0; err and err_code held.
  - Only clear exits, to IDLE.
- Update rules:
  - prev and cur_index update on every valid sample except in FAULT.
  - rev_count holds outside LOCKED.
- clear (synchronous):
  - zeroes err, err_code and rev_count; FAULT->IDLE.
  - In IDLE/ACQUIRE/LOCKED, state is unchanged.
  - clear and a new fault detected in the same cycle: the fault wins (err=1, code set, state FAULT) and rev_count is still zeroed.
  - clear coincident with a revolution step: rev_count=0; rev_pulse still asserts.
- reset_n asserted mid-operation forces the reset values immediately, regardless of clock.

Optional Feature:
- Macro RING_MON_HOLD_EN.
- Defined: stall (phase==prev) is legal in ACQUIRE and LOCKED. It neither advances nor resets count, and raises no fault; err_code 11 is never produced.
- Undefined: stall behaves as specified above (count reset in ACQUIRE, fault 11 in LOCKED).

Test Plan:
- Reset, then drive 0001,0010,0100,1000,0001 on consecutive edges (LOCK_COUNT=4) -> locked=1 after the 4th step; cur_index=0; rev_count=0.
- Locked, continue the rotation for 3 full cycles -> rev_pulse fires 3 times, one cycle each on 1000->0001; rev_count=3.
- Locked, inject phase=0110 -> err=1, err_code=01, locked=0. Then drive clear=1 for one cycle -> err=0, err_code=00, rev_count=0, state IDLE; relock after 4 further correct steps.
- Locked at 0010, drive 1000 -> err_code=10. Separately, locked at 0100, repeat 0100 -> err_code=11 (macro undefined); with RING_MON_HOLD_EN defined, no error and still locked.
- REV_W=2, run 5 revolutions -> rev_count saturates at 3.
- Pulse reset_n low between clock edges while locked -> locked, err and rev_count drop to 0 immediately.
- Fault coincident with clear=1 -> err=1 with the correct code, rev_count=0.

Source files
------------

// File: rtl/ring_phase_monitor.sv
// ring_phase_monitor: checks a rotating 4-bit one-hot phase for validity and
// order (0001->0010->0100->1000->0001). After LOCK_COUNT correct steps it
// locks, counts full revolutions, and latches a sticky fault with a cause
// code on any violation while locked.
// Optional build macro RING_MON_HOLD_EN: when defined, a repeated phase
// (stall) is tolerated in ACQUIRE and LOCKED instead of resetting the step
// count or faulting.
module ring_phase_monitor #(
    parameter int LOCK_COUNT = 4,
    parameter int REV_W      = 8
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [3:0]       phase,
    input  logic             clear,
    output logic             locked,
    output logic             err,
    output logic [1:0]       err_code,
    output logic [REV_W-1:0] rev_count,
    output logic             rev_pulse,
    output logic [1:0]       cur_index
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACQUIRE = 2'd1,
        ST_LOCKED  = 2'd2,
        ST_FAULT   = 2'd3
    } state_t;

    localparam logic [3:0]       LOCK_TARGET = 4'(LOCK_COUNT);
    localparam logic [REV_W-1:0] REV_MAX     = {REV_W{1'b1}};

`ifdef RING_MON_HOLD_EN
    localparam logic STALL_LEGAL = 1'b1;
`else
    localparam logic STALL_LEGAL = 1'b0;
`endif

    localparam logic [1:0] CODE_NONE   = 2'b00;
    localparam logic [1:0] CODE_ONEHOT = 2'b01;
    localparam logic [1:0] CODE_ORDER  = 2'b10;
    localparam logic [1:0] CODE_STALL  = 2'b11;

    // True when exactly one bit of the phase is set.
    function automatic logic is_onehot(input logic [3:0] p);
        return (p != 4'b0000) && ((p & (p - 4'b0001)) == 4'b0000);
    endfunction

    // Expected successor of a one-hot phase.
    function automatic logic [3:0] rotl1(input logic [3:0] p);
        return {p[2:0], p[3]};
    endfunction

    // Binary position of the set bit of a one-hot phase.
    function automatic logic [1:0] onehot_index(input logic [3:0] p);
        logic [1:0] idx;
        case (p)
            4'b0001: idx = 2'd0;
            4'b0010: idx = 2'd1;
            4'b0100: idx = 2'd2;
            4'b1000: idx = 2'd3;
            default: idx = 2'd0;
        endcase
        return idx;
    endfunction

    state_t           state_r;
    state_t           state_nxt_s;
    logic [3:0]       prev_r;
    logic [3:0]       cnt_r;

    logic             valid_s;
    logic             correct_s;
    logic             stall_s;
    logic             wrong_s;
    logic             fault_s;
    logic             rev_step_s;

    logic [3:0]       prev_nxt_s;
    logic [3:0]       cnt_nxt_s;
    logic             locked_nxt_s;
    logic             err_nxt_s;
    logic [1:0]       code_nxt_s;
    logic [REV_W-1:0] rev_nxt_s;
    logic [1:0]       index_nxt_s;

    // Classify the current sample against the last valid sample.
    always_comb begin
        valid_s    = is_onehot(phase);
        correct_s  = valid_s && (phase == rotl1(prev_r));
        stall_s    = valid_s && (phase == prev_r);
        wrong_s    = valid_s && !correct_s && !stall_s;
        rev_step_s = (state_r == ST_LOCKED) && correct_s && (prev_r == 4'b1000);
    end

    // State register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state decision; faults are only detected while locked.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (valid_s) state_nxt_s = ST_ACQUIRE;
                else         state_nxt_s = ST_IDLE;
            end
            ST_ACQUIRE: begin
                if (!valid_s)                                          state_nxt_s = ST_IDLE;
                else if (correct_s && ((cnt_r + 4'd1) == LOCK_TARGET)) state_nxt_s = ST_LOCKED;
                else                                                   state_nxt_s = ST_ACQUIRE;
            end
            ST_LOCKED: begin
                if (!valid_s || wrong_s || (stall_s && !STALL_LEGAL)) state_nxt_s = ST_FAULT;
                else                                                  state_nxt_s = ST_LOCKED;
            end
            ST_FAULT: begin
                if (clear) state_nxt_s = ST_IDLE;
                else       state_nxt_s = ST_FAULT;
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Next values of the datapath and all registered outputs.
    always_comb begin
        fault_s      = (state_r == ST_LOCKED) && (state_nxt_s == ST_FAULT);
        locked_nxt_s = (state_nxt_s == ST_LOCKED);

        // prev/index follow every valid sample except while frozen in FAULT
        if (valid_s && (state_r != ST_FAULT)) begin
            prev_nxt_s  = phase;
            index_nxt_s = onehot_index(phase);
        end else begin
            prev_nxt_s  = prev_r;
            index_nxt_s = cur_index;
        end

        cnt_nxt_s = 4'd0;
        case (state_r)
            ST_ACQUIRE: begin
                if (correct_s)                         cnt_nxt_s = cnt_r + 4'd1;
                else if (stall_s && STALL_LEGAL)       cnt_nxt_s = cnt_r;
                else                                   cnt_nxt_s = 4'd0;
            end
            default: cnt_nxt_s = 4'd0;
        endcase

        // a fault in the same cycle as clear takes precedence
        if (fault_s) begin
            err_nxt_s = 1'b1;
            if (!valid_s)     code_nxt_s = CODE_ONEHOT;
            else if (wrong_s) code_nxt_s = CODE_ORDER;
            else              code_nxt_s = CODE_STALL;
        end else if (clear) begin
            err_nxt_s  = 1'b0;
            code_nxt_s = CODE_NONE;
        end else begin
            err_nxt_s  = err;
            code_nxt_s = err_code;
        end

        if (clear)                                rev_nxt_s = {REV_W{1'b0}};
        else if (rev_step_s && (rev_count != REV_MAX)) rev_nxt_s = rev_count + {{(REV_W-1){1'b0}}, 1'b1};
        else                                      rev_nxt_s = rev_count;
    end

    // Datapath and output registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            prev_r    <= 4'b0000;
            cnt_r     <= 4'd0;
            locked    <= 1'b0;
            err       <= 1'b0;
            err_code  <= CODE_NONE;
            rev_count <= {REV_W{1'b0}};
            rev_pulse <= 1'b0;
            cur_index <= 2'd0;
        end else begin
            prev_r    <= prev_nxt_s;
            cnt_r     <= cnt_nxt_s;
            locked    <= locked_nxt_s;
            err       <= err_nxt_s;
            err_code  <= code_nxt_s;
            rev_count <= rev_nxt_s;
            rev_pulse <= rev_step_s;
            cur_index <= index_nxt_s;
        end
    end

endmodule

// File: tb/tb_ring_phase_monitor.sv
// Testbench for ring_phase_monitor: directed scenarios with literal
// expectations, then randomized phase traffic, all checked every cycle
// against a behavioural model of the monitor's rules. Two instances:
// default parameters, and REV_W=2 / LOCK_COUNT=2 for saturation.
module tb_ring_phase_monitor;

    localparam int M_IDLE = 0, M_ACQ = 1, M_LOCK = 2, M_FAULT = 3;
`ifdef RING_MON_HOLD_EN
    localparam bit HOLD = 1'b1;
`else
    localparam bit HOLD = 1'b0;
`endif

    typedef struct {
        int mode;
        int pidx;     // index of last accepted phase, -1 when none
        int run;
        bit locked;
        bit err;
        int code;
        int rev;
        bit pulse;
        int idx;
    } mdl_t;

    logic       clock;
    logic       reset_n;
    logic [3:0] phase;
    logic       clear;

    logic       lk1, er1, pl1, lk2, er2, pl2;
    logic [1:0] cd1, ix1, cd2, ix2;
    logic [7:0] rv1;
    logic [1:0] rv2;

    int n_assert = 0;
    int n_fail   = 0;
    int pulses   = 0;
    logic [3:0] cur_ph;
    mdl_t m1, m2;

    ring_phase_monitor #(.LOCK_COUNT(4), .REV_W(8)) dut (
        .clock(clock), .reset_n(reset_n), .phase(phase), .clear(clear),
        .locked(lk1), .err(er1), .err_code(cd1), .rev_count(rv1),
        .rev_pulse(pl1), .cur_index(ix1)
    );

    ring_phase_monitor #(.LOCK_COUNT(2), .REV_W(2)) dut2 (
        .clock(clock), .reset_n(reset_n), .phase(phase), .clear(clear),
        .locked(lk2), .err(er2), .err_code(cd2), .rev_count(rv2),
        .rev_pulse(pl2), .cur_index(ix2)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    function automatic mdl_t mreset();
        mdl_t r;
        r.mode = M_IDLE; r.pidx = -1; r.run = 0; r.locked = 1'b0; r.err = 1'b0;
        r.code = 0; r.rev = 0; r.pulse = 1'b0; r.idx = 0;
        return r;
    endfunction

    // One clock of the monitor's rules, expressed on phase indices.
    function automatic mdl_t mstep(mdl_t m, logic [3:0] ph, logic clr, int lockn, int revmax);
        mdl_t n;
        bit v, adv, same, newfault;
        int i;
        n = m;
        v = ($countones(ph) == 1);
        i = -1;
        for (int k = 0; k < 4; k++) if (ph[k]) i = k;
        adv  = v && (m.pidx >= 0) && (i == (m.pidx + 1) % 4);
        same = v && (i == m.pidx);
        newfault = 1'b0;
        n.pulse = 1'b0;
        case (m.mode)
            M_IDLE: if (v) begin n.mode = M_ACQ; n.run = 0; end
            M_ACQ: begin
                if (!v) n.mode = M_IDLE;
                else if (adv) begin
                    n.run = m.run + 1;
                    if (n.run >= lockn) n.mode = M_LOCK;
                end else if (same && HOLD) n.run = m.run;
                else n.run = 0;
            end
            M_LOCK: begin
                if (!v) begin newfault = 1'b1; n.code = 1; end
                else if (adv) begin
                    if (m.pidx == 3) begin
                        n.pulse = 1'b1;
                        if (m.rev < revmax) n.rev = m.rev + 1;
                    end
                end else if (same) begin
                    if (!HOLD) begin newfault = 1'b1; n.code = 3; end
                end else begin newfault = 1'b1; n.code = 2; end
                if (newfault) begin n.mode = M_FAULT; n.err = 1'b1; end
            end
            default: ;
        endcase
        if (clr) begin
            n.rev = 0;
            if (!newfault) begin n.err = 1'b0; n.code = 0; end
            if (m.mode == M_FAULT) n.mode = M_IDLE;
        end
        if (v && m.mode != M_FAULT) begin n.pidx = i; n.idx = i; end
        n.locked = (n.mode == M_LOCK);
        return n;
    endfunction

    // Advance both models on the same edges/reset as the DUTs.
    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            m1 <= mreset();
            m2 <= mreset();
        end else begin
            m1 <= mstep(m1, phase, clear, 4, 255);
            m2 <= mstep(m2, phase, clear, 2, 3);
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cmp(input string tag, input logic lk, input logic er, input logic [1:0] cd,
                       input int rv, input logic pl, input logic [1:0] ix, input mdl_t m);
        chk({tag, ".locked"},    int'(lk), int'(m.locked));
        chk({tag, ".err"},       int'(er), int'(m.err));
        chk({tag, ".err_code"},  int'(cd), m.code);
        chk({tag, ".rev_count"}, rv,       m.rev);
        chk({tag, ".rev_pulse"}, int'(pl), int'(m.pulse));
        chk({tag, ".cur_index"}, int'(ix), m.idx);
    endtask

    // Compare both DUTs against the model away from the active edge.
    always @(negedge clock) begin
        cmp("u1", lk1, er1, cd1, int'(rv1), pl1, ix1, m1);
        cmp("u2", lk2, er2, cd2, int'(rv2), pl2, ix2, m2);
    end

    task automatic drive(input logic [3:0] ph, input logic clr);
        phase = ph;
        clear = clr;
        @(posedge clock);
        #2;
        clear = 1'b0;
    endtask

    task automatic rotate(input int n);
        for (int k = 0; k < n; k++) begin
            cur_ph = (cur_ph == 4'b0000) ? 4'b0001 : {cur_ph[2:0], cur_ph[3]};
            drive(cur_ph, 1'b0);
            if (pl1) pulses++;
        end
    endtask

    initial begin
        logic [3:0] rp;
        int r;
        reset_n = 1'b0;
        phase   = 4'b0000;
        clear   = 1'b0;
        cur_ph  = 4'b1000;
        m1 = mreset();
        m2 = mreset();
        repeat (3) @(posedge clock);
        #2 reset_n = 1'b1;

        // reset values
        chk("rst.locked", int'(lk1), 0);
        chk("rst.err", int'(er1), 0);
        chk("rst.rev_count", int'(rv1), 0);
        chk("rst.cur_index", int'(ix1), 0);

        // acquire and lock after four correct steps
        drive(4'b0001, 1'b0);
        drive(4'b0010, 1'b0);
        drive(4'b0100, 1'b0);
        drive(4'b1000, 1'b0);
        chk("lock.before", int'(lk1), 0);
        drive(4'b0001, 1'b0);
        chk("lock.locked", int'(lk1), 1);
        chk("lock.cur_index", int'(ix1), 0);
        chk("lock.rev_count", int'(rv1), 0);

        // three full revolutions
        cur_ph = 4'b0001;
        pulses = 0;
        rotate(12);
        chk("rev3.pulses", pulses, 3);
        chk("rev3.rev_count", int'(rv1), 3);
        chk("rev3.sat2", int'(rv2), 3);

        // not one-hot fault, then clear and relock
        drive(4'b0110, 1'b0);
        chk("onehot.err", int'(er1), 1);
        chk("onehot.code", int'(cd1), 1);
        chk("onehot.locked", int'(lk1), 0);
        drive(4'b0000, 1'b1);
        chk("clr.err", int'(er1), 0);
        chk("clr.code", int'(cd1), 0);
        chk("clr.rev_count", int'(rv1), 0);
        rotate(5);
        chk("relock.locked", int'(lk1), 1);
        chk("relock.cur_index", int'(ix1), 1);

        // wrong order from 0010
        drive(4'b1000, 1'b0);
        chk("order.code", int'(cd1), 2);
        chk("order.err", int'(er1), 1);
        drive(4'b0000, 1'b1);
        rotate(5);
        chk("relock2.cur_index", int'(ix1), 2);
        chk("relock2.locked", int'(lk1), 1);

        // stall at 0100
        drive(4'b0100, 1'b0);
`ifdef RING_MON_HOLD_EN
        chk("stall.err", int'(er1), 0);
        chk("stall.locked", int'(lk1), 1);
`else
        chk("stall.err", int'(er1), 1);
        chk("stall.code", int'(cd1), 3);
`endif

        // clear, relock, five revolutions on the narrow counter
        cur_ph = 4'b1000;
        drive(cur_ph, 1'b1);
        rotate(24);
        chk("sat.rev_count", int'(rv2), 3);

        // asynchronous reset between edges while locked
        chk("arst.pre", int'(lk1), 1);
        reset_n = 1'b0;
        #1;
        chk("arst.locked", int'(lk1), 0);
        chk("arst.err", int'(er1), 0);
        chk("arst.rev_count", int'(rv1), 0);
        #1 reset_n = 1'b1;

        // fault coincident with clear
        rotate(9);
        chk("fc.pre_rev", int'(rv1), 1);
        drive(4'b0000, 1'b1);
        chk("fc.err", int'(er1), 1);
        chk("fc.code", int'(cd1), 1);
        chk("fc.rev_count", int'(rv1), 0);
        chk("fc.locked", int'(lk1), 0);
        drive(4'b0000, 1'b1);

        // randomized traffic
        for (int k = 0; k < 1500; k++) begin
            r = $urandom_range(0, 99);
            if (r < 80) begin
                cur_ph = (cur_ph == 4'b0000) ? 4'b0001 : {cur_ph[2:0], cur_ph[3]};
                rp = cur_ph;
            end else if (r < 87) begin
                rp = cur_ph;
            end else if (r < 93) begin
                rp = 4'b0001 << $urandom_range(0, 3);
                cur_ph = rp;
            end else begin
                rp = 4'($urandom_range(0, 15));
            end
            drive(rp, ($urandom_range(0, 99) < 4));
        end

        @(negedge clock);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
